clock_gate_sequencer: RTL

Sequencing controller that drives the `COND` input of a clock gater and owns the gating protocol for one gated domain. Sleep is requested at a level. The controller withholds `READY` and waits for the downstream logic to go idle before deasserting `COND`. On wake, it reasserts `COND` and holds `READY` low for a settle interval. It runs on the ungated source clock and sits between power-management logic and the clock gater.

---
 rtl/clock_gate_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clock_gate_sequencer.sv
// clock_gate_sequencer: owns the COND/READY protocol of one gated clock domain.
// Sleep is a level request; the domain is drained (BUSY must stay low for
// IDLE_CYCLES consecutive samples) before COND drops, and on wake READY is
// held off for WAKE_CYCLES after COND returns. Runs on the ungated clock.
module clock_gate_sequencer #(
    parameter bit init        = 1'b1,
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SLEEP_REQ,
    input  logic        BUSY,
    output logic        COND,
    output logic        READY,
    output logic        ASLEEP,
    output logic [1:0]  STATE,
    output logic [15:0] SLEEP_CNT
);

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    localparam state_e RST_STATE = init ? ST_ON : ST_OFF;

    // Compare limits, truncated to the counter width.
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES - 1);

    // Out-of-range parameters are rejected when the design is elaborated.
    if (IDLE_CYCLES < 1 || IDLE_CYCLES >= (1 << CNT_W)) begin : g_bad_idle
        $error("clock_gate_sequencer: IDLE_CYCLES out of range 1..2^CNT_W-1");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES >= (1 << CNT_W)) begin : g_bad_wake
        $error("clock_gate_sequencer: WAKE_CYCLES out of range 1..2^CNT_W-1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        sleep_cnt_q, sleep_cnt_d;
    logic               cond_q, cond_d;
    logic               ready_q, ready_d;
    logic               asleep_q, asleep_d;

    // Next-state, shared drain/wake counter and sleep statistics.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sleep_cnt_d = sleep_cnt_q;
        case (state_q)
            ST_ON: begin
                if (SLEEP_REQ) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // A dropped request aborts the drain before anything else.
                if (!SLEEP_REQ) begin
                    state_d = ST_ON;
                end else if (BUSY) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LIM) begin
                    state_d = ST_OFF;
                    if (sleep_cnt_q != 16'hFFFF) sleep_cnt_d = sleep_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (!SLEEP_REQ) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion; SLEEP_REQ is not looked at.
                if (cnt_q == WAKE_LIM) state_d = ST_ON;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = RST_STATE;
        endcase

        // Outputs are flopped from the next state so COND reaches the gater
        // straight from a register, with no decode glitches.
        cond_d   = (state_d != ST_OFF);
        ready_d  = (state_d == ST_ON);
        asleep_d = (state_d == ST_OFF);
    end

    // State, counters and decoded outputs; reset returns to the init state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            sleep_cnt_q <= '0;
            cond_q      <= init;
            ready_q     <= init;
            asleep_q    <= !init;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sleep_cnt_q <= sleep_cnt_d;
            cond_q      <= cond_d;
            ready_q     <= ready_d;
            asleep_q    <= asleep_d;
        end
    end

    assign COND      = cond_q;
    assign READY     = ready_q;
    assign ASLEEP    = asleep_q;
    assign STATE     = state_q;
    assign SLEEP_CNT = sleep_cnt_q;

endmodule
